// File: rtl/hc595_serial_driver.sv
`default_nettype none
// ============================================================================
//  Module   : hc595_serial_driver
//  Brief    : Shifts one 16-bit digit word per handshake into two cascaded
//             74HC595 registers, then pulses the storage clock.
//  Config   : define HC595_LSB_FIRST_EN for LSB-first shift order.
//  Revision : 1.0 - initial release
// ============================================================================
module hc595_serial_driver #(
    parameter int CLK_DIV = 4,
    parameter int DAT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DAT_W-1:0] dat,
    input  logic             vld,
    output logic             rdy,
    output logic             sclk,
    output logic             rclk,
    output logic             dio
);

    localparam int c_div_w = $clog2(CLK_DIV + 1);
    localparam int c_bit_w = $clog2(DAT_W);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DAT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT_LO = 2'd1,
        ST_SHIFT_HI = 2'd2,
        ST_LATCH    = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_div_w-1:0] r_div;
    logic [c_bit_w-1:0] r_bit;
    logic [DAT_W-1:0]   r_shift;
    logic               r_rdy;
    logic               r_sclk;
    logic               r_rclk;
    logic               r_dio;

    logic               w_div_done;
    logic               w_first_bit;
    logic               w_next_bit;
    logic [DAT_W-1:0]   w_next_shift;

    assign w_div_done = (r_div == c_div_last);

    // The shift register rotates so the bit presented next always sits next to the one on dio.
`ifdef HC595_LSB_FIRST_EN
    assign w_first_bit  = dat[0];
    assign w_next_bit   = r_shift[1];
    assign w_next_shift = {r_shift[0], r_shift[DAT_W-1:1]};
`else
    assign w_first_bit  = dat[DAT_W-1];
    assign w_next_bit   = r_shift[DAT_W-2];
    assign w_next_shift = {r_shift[DAT_W-2:0], r_shift[DAT_W-1]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_rdy   <= 1'b1;
            r_sclk  <= 1'b0;
            r_rclk  <= 1'b0;
            r_dio   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (vld && r_rdy) begin
                        r_shift <= dat;
                        r_dio   <= w_first_bit;
                        r_bit   <= '0;
                        r_div   <= '0;
                        r_rdy   <= 1'b0;
                        r_state <= ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (w_div_done) begin
                        r_sclk  <= 1'b1;
                        r_div   <= '0;
                        r_state <= ST_SHIFT_HI;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (w_div_done) begin
                        r_sclk <= 1'b0;
                        r_div  <= '0;
                        // dio only moves on the falling sclk edge, giving a full half-period of setup/hold.
                        if (r_bit == c_bit_last) begin
                            r_rclk  <= 1'b1;
                            r_state <= ST_LATCH;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= w_next_shift;
                            r_dio   <= w_next_bit;
                            r_state <= ST_SHIFT_LO;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (w_div_done) begin
                        r_rclk  <= 1'b0;
                        r_rdy   <= 1'b1;
                        r_div   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdy  = r_rdy;
    assign sclk = r_sclk;
    assign rclk = r_rclk;
    assign dio  = r_dio;

endmodule
`default_nettype wire

// File: tb/tb_hc595_serial_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hc595_serial_driver
//  Brief    : Randomized bench for hc595_serial_driver (CLK_DIV=4 and 1)
//             against a cycle-offset reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hc595_serial_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [2];
    logic        vld  [2];
    logic [15:0] dat  [2];
    logic        rdy  [2];
    logic        sclk [2];
    logic        rclk [2];
    logic        dio  [2];

    hc595_serial_driver #(.CLK_DIV(4), .DAT_W(16)) u_dut0 (
        .clk(clk), .rst(rst[0]), .dat(dat[0]), .vld(vld[0]),
        .rdy(rdy[0]), .sclk(sclk[0]), .rclk(rclk[0]), .dio(dio[0])
    );

    hc595_serial_driver #(.CLK_DIV(1), .DAT_W(16)) u_dut1 (
        .clk(clk), .rst(rst[1]), .dat(dat[1]), .vld(vld[1]),
        .rdy(rdy[1]), .sclk(sclk[1]), .rclk(rclk[1]), .dio(dio[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one transfer is a timeline of 33*D cycles counted from the accept edge.
    int          div    [2];
    bit          busy   [2];
    int          k      [2];
    logic [15:0] word   [2];
    logic [15:0] cap    [2];
    int          ncap   [2];
    int          nlatch [2];
    logic        psclk  [2];
    logic        prclk  [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [15:0] w, input int j);
`ifdef HC595_LSB_FIRST_EN
        return w[j];
`else
        return w[15-j];
`endif
    endfunction

    // Bits captured at sclk rises, first one ending up in the MSB.
    function automatic logic [15:0] exp_cap(input logic [15:0] w);
        logic [15:0] r;
        for (int j = 0; j < 16; j++) r[15-j] = exp_bit(w, j);
        return r;
    endfunction

    task automatic check_outputs(input int u);
        int   d;
        logic er, es, erc;
        d = div[u];
        if (busy[u]) begin
            er  = 1'b0;
            es  = (k[u] >= d) && (k[u] < 32*d) && (((k[u] / d) % 2) == 1);
            erc = (k[u] >= 32*d);
        end else begin
            er  = 1'b1;
            es  = 1'b0;
            erc = 1'b0;
        end
        check("rdy",  32'(rdy[u]),  32'(er));
        check("sclk", 32'(sclk[u]), 32'(es));
        check("rclk", 32'(rclk[u]), 32'(erc));
        if (busy[u] && k[u] < 32*d)
            check("dio", 32'(dio[u]), 32'(exp_bit(word[u], k[u] / (2*d))));
        if (sclk[u] && !psclk[u]) begin
            cap[u] = {cap[u][14:0], dio[u]};
            ncap[u]++;
        end
        if (rclk[u] && !prclk[u]) begin
            nlatch[u]++;
            check("latched_word", 32'(cap[u]), 32'(exp_cap(word[u])));
            check("sclk_rises", 32'(ncap[u]), 32'd16);
        end
        psclk[u] = sclk[u];
        prclk[u] = rclk[u];
    endtask

    task automatic tick(input int u, input logic v, input logic [15:0] d, output bit acc);
        @(negedge clk);
        check_outputs(u);
        vld[u] = v;
        dat[u] = d;
        acc = 1'b0;
        if (!busy[u]) begin
            if (v && !rst[u]) begin
                busy[u] = 1'b1;
                k[u]    = 0;
                word[u] = d;
                cap[u]  = '0;
                ncap[u] = 0;
                acc     = 1'b1;
            end
        end else begin
            k[u]++;
            if (k[u] == 33*div[u]) busy[u] = 1'b0;
        end
    endtask

    task automatic idle(input int u, input int n);
        bit a;
        repeat (n) tick(u, 1'b0, 16'h0000, a);
    endtask

    task automatic do_reset(input int u);
        bit a;
        @(negedge clk);
        rst[u] = 1'b1;
        vld[u] = 1'b0;
        #1;
        check("rst_rdy",  32'(rdy[u]),  32'd1);
        check("rst_sclk", 32'(sclk[u]), 32'd0);
        check("rst_rclk", 32'(rclk[u]), 32'd0);
        check("rst_dio",  32'(dio[u]),  32'd0);
        busy[u]  = 1'b0;
        k[u]     = 0;
        ncap[u]  = 0;
        psclk[u] = 1'b0;
        prclk[u] = 1'b0;
        tick(u, 1'b0, 16'h0000, a);
        tick(u, 1'b0, 16'h0000, a);
        rst[u] = 1'b0;
    endtask

    initial begin
        bit          a;
        int          idx;
        int          guard;
        int          base;
        logic [15:0] words [8];

        div = '{4, 1};
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; vld[u] = 1'b0; dat[u] = '0;
            busy[u] = 1'b0; k[u] = 0; word[u] = '0; cap[u] = '0;
            ncap[u] = 0; nlatch[u] = 0; psclk[u] = 1'b0; prclk[u] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("init_rdy",  32'(rdy[u]),  32'd1);
            check("init_sclk", 32'(sclk[u]), 32'd0);
            check("init_rclk", 32'(rclk[u]), 32'd0);
            check("init_dio",  32'(dio[u]),  32'd0);
            rst[u] = 1'b0;
        end

        // Single transfer of 0xC001 at CLK_DIV=4
        tick(0, 1'b1, 16'hC001, a);
        check("t1_accept", 32'(a), 32'd1);
        idle(0, 140);
        check("t1_latches", 32'(nlatch[0]), 32'd1);

        // Eight words with vld held high; the scanner advances on each accept
        for (int i = 0; i < 8; i++) words[i] = {8'($urandom), 8'(1 << i)};
        base = nlatch[0]; idx = 0; guard = 0;
        while (idx < 8 && guard < 8*140) begin
            tick(0, 1'b1, words[idx], a);
            if (a) idx++;
            guard++;
        end
        check("t2_all_accepted", 32'(idx), 32'd8);
        idle(0, 140);
        check("t2_latches", 32'(nlatch[0] - base), 32'd8);

        // dat/vld changes mid-transfer are ignored
        base = nlatch[0];
        tick(0, 1'b1, 16'h0000, a);
        idle(0, 39);
        tick(0, 1'b1, 16'hFFFF, a);
        check("t3_no_accept", 32'(a), 32'd0);
        idle(0, 140);
        check("t3_latches", 32'(nlatch[0] - base), 32'd1);

        // Reset at cycle 60 aborts without a storage pulse
        base = nlatch[0];
        tick(0, 1'b1, 16'($urandom), a);
        idle(0, 59);
        do_reset(0);
        idle(0, 140);
        check("t4_no_latch", 32'(nlatch[0] - base), 32'd0);
        tick(0, 1'b1, 16'($urandom), a);
        idle(0, 140);
        check("t4_after_reset", 32'(nlatch[0] - base), 32'd1);

        // Random traffic at CLK_DIV=4
        repeat (3000) tick(0, 1'($urandom_range(0, 1)), 16'($urandom), a);
        idle(0, 140);

        // CLK_DIV=1
        base = nlatch[1];
        tick(1, 1'b1, 16'hA55A, a);
        idle(1, 40);
        check("t5_latches", 32'(nlatch[1] - base), 32'd1);
        tick(1, 1'b1, 16'h0001, a);
        idle(1, 40);
        repeat (600) tick(1, 1'($urandom_range(0, 1)), 16'($urandom), a);
        idle(1, 40);
        check("t5_random_latches", 32'(nlatch[1] > base + 10), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
